window_feeder: RTL and testbench

WINDOW_FEEDER -- requirements
Module: window_feeder

---
 rtl/window_feeder_pkg.sv | 17 +
 rtl/window_feeder_valid_delay.sv | 31 +++
 rtl/window_feeder.sv | 150 +++++++++++++++
 tb/tb_window_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_feeder_pkg.sv
// rtl/window_feeder_pkg.sv - shared widths and FSM state type for window_feeder
// Purpose: data/weight bus widths and the row-tracking state enum used by
//          window_feeder and its testbench.
// Ports:   none (package).
package window_feeder_pkg;

    localparam int DATA_W = 5;
    localparam int WBUS_W = 20;

    // IDLE: no samples of the current row seen; FILL: 1-3 seen; RUN: window full.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/window_feeder_valid_delay.sv
// rtl/window_feeder_valid_delay.sv - fixed-depth delay line for a single-bit pulse
// Purpose: delays i_d by exactly DEPTH clock cycles (DEPTH >= 1).
// Ports:   clk - rising-edge clock
//          rst - asynchronous active-high reset, empties the line
//          i_d - pulse in
//          o_q - pulse out, DEPTH cycles later
module valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/window_feeder.sv
// rtl/window_feeder.sv - 4-tap activation window feeder with weight holding
// Purpose: shifts accepted activation samples into a 4-entry window and
//          presents the window (A1 oldest .. A4 newest) with a one-cycle
//          enReg pulse once the window is full and then every STRIDE-th
//          accept; each row (terminated by in_last) starts from scratch.
//          res_valid is enReg delayed PU_LATENCY cycles.
// Config:  WINDOW_FEEDER_ZERO_PAD_EN - rows start with three zeros in the
//          window, so the first accept of a row already emits.
// Ports:   clk, rst         - clock, asynchronous active-high reset
//          in_valid/in_data/in_last/in_ready - activation sample handshake
//          w_load/w_data    - weight set load (priority over samples)
//          A1..A4           - emitted activation window
//          W1..W4           - held weights
//          enReg            - new window on A1..A4 this cycle
//          res_valid        - downstream result valid
module window_feeder
    import window_feeder_pkg::*;
#(
    parameter int STRIDE     = 1,
    parameter int PU_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              w_load,
    input  logic [WBUS_W-1:0] w_data,
    output logic [DATA_W-1:0] A1,
    output logic [DATA_W-1:0] A2,
    output logic [DATA_W-1:0] A3,
    output logic [DATA_W-1:0] A4,
    output logic [DATA_W-1:0] W1,
    output logic [DATA_W-1:0] W2,
    output logic [DATA_W-1:0] W3,
    output logic [DATA_W-1:0] W4,
    output logic              enReg,
    output logic              res_valid
);

    localparam logic [2:0] LP_STRIDE = 3'(STRIDE);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_fill, w_fill_nxt;
    logic [2:0]        r_stride, w_stride_nxt;
    logic [DATA_W-1:0] r_win [4];
    logic [DATA_W-1:0] w_shift [4];
    logic [DATA_W-1:0] r_a [4];
    logic [DATA_W-1:0] r_w [4];
    logic              r_en;
    logic              w_accept;
    logic              w_emit;

    assign in_ready = ~w_load;
    assign w_accept = in_valid & ~w_load;

    always_comb begin
        w_shift      = '{r_win[1], r_win[2], r_win[3], in_data};
        w_state_nxt  = r_state;
        w_fill_nxt   = r_fill;
        w_stride_nxt = r_stride;
        w_emit       = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
`ifdef WINDOW_FEEDER_ZERO_PAD_EN
                    w_emit       = 1'b1;
                    w_state_nxt  = ST_RUN;
                    w_stride_nxt = 3'd0;
`else
                    w_state_nxt  = ST_FILL;
                    w_fill_nxt   = 2'd1;
`endif
                end
                ST_FILL: begin
                    if (r_fill == 2'd3) begin
                        w_emit       = 1'b1;
                        w_state_nxt  = ST_RUN;
                        w_stride_nxt = 3'd0;
                    end else begin
                        w_fill_nxt = r_fill + 2'd1;
                    end
                end
                ST_RUN: begin
                    if (r_stride + 3'd1 == LP_STRIDE) begin
                        w_emit       = 1'b1;
                        w_stride_nxt = 3'd0;
                    end else begin
                        w_stride_nxt = r_stride + 3'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
            // Row end: any window this sample produced is still emitted above.
            if (in_last) begin
                w_state_nxt  = ST_IDLE;
                w_fill_nxt   = 2'd0;
                w_stride_nxt = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_fill   <= 2'd0;
            r_stride <= 3'd0;
            r_en     <= 1'b0;
            r_win    <= '{default: '0};
            r_a      <= '{default: '0};
            r_w      <= '{default: '0};
        end else begin
            r_state  <= w_state_nxt;
            r_fill   <= w_fill_nxt;
            r_stride <= w_stride_nxt;
            r_en     <= w_emit;
            // Clearing at row end doubles as the zero pre-load for padded rows.
            if (w_accept) begin
                r_win <= in_last ? '{default: '0} : w_shift;
            end
            if (w_emit) begin
                r_a <= w_shift;
            end
            if (w_load) begin
                r_w <= '{w_data[4:0], w_data[9:5], w_data[14:10], w_data[19:15]};
            end
        end
    end

    valid_delay #(
        .DEPTH(PU_LATENCY)
    ) u_valid_delay (
        .clk (clk),
        .rst (rst),
        .i_d (r_en),
        .o_q (res_valid)
    );

    assign A1    = r_a[0];
    assign A2    = r_a[1];
    assign A3    = r_a[2];
    assign A4    = r_a[3];
    assign W1    = r_w[0];
    assign W2    = r_w[1];
    assign W3    = r_w[2];
    assign W4    = r_w[3];
    assign enReg = r_en;

endmodule

// File: tb/tb_window_feeder.sv
// tb/tb_window_feeder.sv - self-checking bench for window_feeder (STRIDE 1 and 2)
module tb_window_feeder;

    localparam int PU = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        w_load = 1'b0;
    logic [19:0] w_data = '0;

    logic        rdy [2];
    logic [4:0]  a1 [2], a2 [2], a3 [2], a4 [2];
    logic [4:0]  wt1 [2], wt2 [2], wt3 [2], wt4 [2];
    logic        en [2];
    logic        rv [2];

    always #5 clk = ~clk;

    window_feeder #(.STRIDE(1), .PU_LATENCY(PU)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy[0]), .w_load(w_load), .w_data(w_data),
        .A1(a1[0]), .A2(a2[0]), .A3(a3[0]), .A4(a4[0]),
        .W1(wt1[0]), .W2(wt2[0]), .W3(wt3[0]), .W4(wt4[0]),
        .enReg(en[0]), .res_valid(rv[0])
    );

    window_feeder #(.STRIDE(2), .PU_LATENCY(PU)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy[1]), .w_load(w_load), .w_data(w_data),
        .A1(a1[1]), .A2(a2[1]), .A3(a3[1]), .A4(a4[1]),
        .W1(wt1[1]), .W2(wt2[1]), .W3(wt3[1]), .W4(wt4[1]),
        .enReg(en[1]), .res_valid(rv[1])
    );

    int tests = 0;
    int fails = 0;

    // Model: the row as a plain list of accepted samples; windows are its last four.
    int          stride_of [2];
    logic [4:0]  row [2][64];
    int          row_n [2];
    logic [19:0] m_win [2];
    logic [19:0] m_w;
    logic [7:0]  en_hist [2];

    // Windows and res_valid pulses actually seen on the DUT outputs.
    logic [19:0] cap [2][16];
    int          cap_n [2];
    int          rv_cnt [2];

    function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
        return {a[4:0], b[4:0], c[4:0], d[4:0]};
    endfunction

    function automatic logic [4:0] sample_at(input int k, input int i);
        return (i < 0) ? 5'd0 : row[k][i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            row_n[k]   = 0;
            m_win[k]   = '0;
            en_hist[k] = '0;
            cap_n[k]   = 0;
            rv_cnt[k]  = 0;
        end
        m_w = '0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit emit;
            int n;
            emit = 1'b0;
            if (in_valid && !w_load) begin
                row[k][row_n[k]] = in_data;
                row_n[k]++;
                n = row_n[k];
`ifdef WINDOW_FEEDER_ZERO_PAD_EN
                emit = ((n - 1) % stride_of[k]) == 0;
`else
                emit = (n >= 4) && (((n - 4) % stride_of[k]) == 0);
`endif
                if (emit)
                    m_win[k] = {sample_at(k, n-4), sample_at(k, n-3),
                                sample_at(k, n-2), sample_at(k, n-1)};
                if (in_last) row_n[k] = 0;
            end
            en_hist[k] = {en_hist[k][6:0], emit};
        end
        if (w_load) m_w = w_data;
    endtask

    task automatic compare(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s ready s%0d", tag, k+1), {31'b0, rdy[k]}, {31'b0, ~w_load});
            chk($sformatf("%s window s%0d", tag, k+1),
                {12'b0, a1[k], a2[k], a3[k], a4[k]}, {12'b0, m_win[k]});
            chk($sformatf("%s weights s%0d", tag, k+1),
                {12'b0, wt4[k], wt3[k], wt2[k], wt1[k]}, {12'b0, m_w});
            chk($sformatf("%s enReg s%0d", tag, k+1), {31'b0, en[k]}, {31'b0, en_hist[k][0]});
            chk($sformatf("%s res_valid s%0d", tag, k+1), {31'b0, rv[k]}, {31'b0, en_hist[k][PU]});
            if (en[k] === 1'b1 && cap_n[k] < 16) begin
                cap[k][cap_n[k]] = {a1[k], a2[k], a3[k], a4[k]};
                cap_n[k]++;
            end
            if (rv[k] === 1'b1) rv_cnt[k]++;
        end
    endtask

    task automatic step(input logic v, input int d, input logic l, input logic wl, input logic [19:0] wd);
        in_valid = v;
        in_data  = d[4:0];
        in_last  = l;
        w_load   = wl;
        w_data   = wd;
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
        compare("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 20'h0);
    endtask

    task automatic send_seq(input int first, input int cnt, input bit last_at_end);
        for (int i = 0; i < cnt; i++)
            step(1'b1, first + i, (last_at_end && i == cnt - 1), 1'b0, 20'h0);
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        w_load   = 1'b0;
        #1;
        model_reset();
        compare("rst_async");
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare("rst_hold");
        end
        rst = 1'b0;
    endtask

    task automatic clear_caps();
        for (int k = 0; k < 2; k++) begin
            cap_n[k]  = 0;
            rv_cnt[k] = 0;
        end
    endtask

    task automatic expect_caps(input int k, input int n, input logic [19:0] e0,
                               input logic [19:0] e1, input logic [19:0] e2, input string tag);
        logic [19:0] e [3];
        e = '{e0, e1, e2};
        chk($sformatf("%s count s%0d", tag, k+1), cap_n[k], n);
        for (int i = 0; i < n && i < 3 && i < cap_n[k]; i++)
            chk($sformatf("%s win%0d s%0d", tag, i, k+1), {12'b0, cap[k][i]}, {12'b0, e[i]});
    endtask

    initial begin
        stride_of[0] = 1;
        stride_of[1] = 2;
        model_reset();
        do_reset(2);

        // Weight load on its own: 0x8C631 packs 17 into every field.
        step(1'b0, 0, 1'b0, 1'b1, 20'h8C631);
        chk("wload ready low", {31'b0, rdy[0]}, 32'd0);
        chk("wload weights", {12'b0, wt1[0], wt2[0], wt3[0], wt4[0]}, {12'b0, pk(17, 17, 17, 17)});
        idle(2);

        // STRIDE 1 / 2, row 1..5
        clear_caps();
        send_seq(1, 5, 1'b1);
        idle(6);
`ifndef WINDOW_FEEDER_ZERO_PAD_EN
        expect_caps(0, 2, pk(1,2,3,4), pk(2,3,4,5), 20'h0, "row5");
        expect_caps(1, 1, pk(1,2,3,4), 20'h0, 20'h0, "row5");
        chk("row5 res_valid pulses s1", rv_cnt[0], 32'd2);
`endif

        // Row 1..8
        clear_caps();
        send_seq(1, 8, 1'b1);
        idle(6);
`ifndef WINDOW_FEEDER_ZERO_PAD_EN
        expect_caps(1, 3, pk(1,2,3,4), pk(3,4,5,6), pk(5,6,7,8), "row8");
        chk("row8 count s1", cap_n[0], 32'd5);
`endif

        // Partial row 7, 9
        clear_caps();
        step(1'b1, 7, 1'b0, 1'b0, 20'h0);
        step(1'b1, 9, 1'b1, 1'b0, 20'h0);
        idle(6);
`ifdef WINDOW_FEEDER_ZERO_PAD_EN
        expect_caps(0, 2, pk(0,0,0,7), pk(0,0,7,9), 20'h0, "partial");
        expect_caps(1, 1, pk(0,0,0,7), 20'h0, 20'h0, "partial");
`else
        expect_caps(0, 0, 20'h0, 20'h0, 20'h0, "partial");
        expect_caps(1, 0, 20'h0, 20'h0, 20'h0, "partial");
`endif

        // Weight load colliding with a valid sample mid-row
        clear_caps();
        step(1'b0, 0, 1'b0, 1'b1, 20'h12345);
        send_seq(1, 2, 1'b0);
        step(1'b1, 30, 1'b0, 1'b1, 20'h8C631);
        chk("collide ready low", {31'b0, rdy[0]}, 32'd0);
        send_seq(3, 2, 1'b1);
        idle(6);
        chk("collide weights", {12'b0, wt1[0], wt2[0], wt3[0], wt4[0]}, {12'b0, pk(17, 17, 17, 17)});
`ifndef WINDOW_FEEDER_ZERO_PAD_EN
        expect_caps(0, 1, pk(1,2,3,4), 20'h0, 20'h0, "collide");
`endif

        // Back-to-back rows
        clear_caps();
        send_seq(1, 4, 1'b1);
        send_seq(5, 4, 1'b1);
        idle(6);
`ifndef WINDOW_FEEDER_ZERO_PAD_EN
        expect_caps(0, 2, pk(1,2,3,4), pk(5,6,7,8), 20'h0, "b2b");
        expect_caps(1, 2, pk(1,2,3,4), pk(5,6,7,8), 20'h0, "b2b");
`endif

        // Reset with a window in flight, then reset mid-FILL
        send_seq(1, 4, 1'b0);
        do_reset(1);
        idle(5);
        send_seq(5, 2, 1'b0);
        do_reset(1);
        idle(5);
        chk("no res_valid after reset s1", rv_cnt[0], 32'd0);
        chk("no res_valid after reset s2", rv_cnt[1], 32'd0);
        send_seq(1, 4, 1'b1);
        idle(6);
`ifndef WINDOW_FEEDER_ZERO_PAD_EN
        expect_caps(0, 1, pk(1,2,3,4), 20'h0, 20'h0, "post_rst");
        chk("post_rst res_valid pulses s1", rv_cnt[0], 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
